// File: rtl/timer_scheduler.sv
// Round-robin scheduler that time-shares one memory-mapped timer between CH_NUM
// one-shot delay requesters, acting as the timer's only bus master.
module timer_scheduler #(
  parameter int CH_NUM  = 4,
  parameter int DELAY_W = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CH_NUM-1:0]         req,
  input  logic [CH_NUM*DELAY_W-1:0] req_delay,
  output logic [CH_NUM-1:0]         done,
  output logic [2:0]                gnt_id,
  output logic                      busy,
  output logic                      t_cs_,
  output logic                      t_as_,
  output logic                      t_rw,
  output logic [29:0]               t_addr,
  output logic [31:0]               t_wr_data,
  input  logic                      t_rdy_,
  input  logic                      t_irq
);

  localparam logic [1:0] A_CTRL = 2'd0;
  localparam logic [1:0] A_INTR = 2'd1;
  localparam logic [1:0] A_EXPR = 2'd2;
  localparam logic [1:0] A_CNT  = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE, S_STOP, S_CLR_CNT, S_SET_EXPR, S_CLR_IRQ0,
    S_START, S_WAIT_IRQ, S_CLR_IRQ, S_DONE
  } state_e;

  state_e       state_q, state_d;
  logic         gap_q, gap_d;
  logic [2:0]   gnt_q, gnt_d;
  logic [2:0]   ptr_q, ptr_d;
  logic [31:0]  dly_q, dly_d;

  logic         sel_found;
  logic [2:0]   sel_idx;
  logic [31:0]  dly_arr [8];

  logic         wr_en;
  logic [1:0]   wr_addr;
  logic [31:0]  wr_data;
  state_e       wr_next;
  logic         strobe;

  for (genvar g = 0; g < 8; g++) begin : g_dly
    if (g < CH_NUM) begin : g_used
      assign dly_arr[g] = req_delay[g*DELAY_W +: DELAY_W];
    end else begin : g_unused
      assign dly_arr[g] = '0;
    end
  end

  // Rotating priority: channels at or above the pointer first, then wrap.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int j = 0; j < CH_NUM; j++) begin
      if (!sel_found && req[j] && (3'(j) >= ptr_q)) begin
        sel_found = 1'b1;
        sel_idx   = 3'(j);
      end
    end
    for (int j = 0; j < CH_NUM; j++) begin
      if (!sel_found && req[j]) begin
        sel_found = 1'b1;
        sel_idx   = 3'(j);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    dly_d   = dly_q;
    wr_en   = 1'b0;
    wr_addr = A_CTRL;
    wr_data = '0;
    wr_next = state_q;

    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          gnt_d   = sel_idx;
          dly_d   = dly_arr[sel_idx];
          gap_d   = 1'b0;
          state_d = S_STOP;
        end
      end
      S_STOP:     begin wr_en = 1'b1; wr_addr = A_CTRL; wr_data = '0;    wr_next = S_CLR_CNT;  end
      S_CLR_CNT:  begin wr_en = 1'b1; wr_addr = A_CNT;  wr_data = '0;    wr_next = S_SET_EXPR; end
      S_SET_EXPR: begin wr_en = 1'b1; wr_addr = A_EXPR; wr_data = dly_q; wr_next = S_CLR_IRQ0; end
      S_CLR_IRQ0: begin wr_en = 1'b1; wr_addr = A_INTR; wr_data = '0;    wr_next = S_START;    end
      S_START:    begin wr_en = 1'b1; wr_addr = A_CTRL; wr_data = 32'h1; wr_next = S_WAIT_IRQ; end
      S_WAIT_IRQ: begin
        if (t_irq) state_d = S_CLR_IRQ;
      end
      S_CLR_IRQ:  begin wr_en = 1'b1; wr_addr = A_INTR; wr_data = '0;    wr_next = S_DONE;     end
      S_DONE: begin
        ptr_d   = (gnt_q == 3'(CH_NUM - 1)) ? 3'd0 : gnt_q + 3'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Strobe held until ready is seen, then one released cycle before moving on.
    if (wr_en) begin
      if (gap_q) begin
        gap_d   = 1'b0;
        state_d = wr_next;
      end else if (!t_rdy_) begin
        gap_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      gap_q   <= 1'b0;
      gnt_q   <= '0;
      ptr_q   <= '0;
      dly_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      dly_q   <= dly_d;
    end
  end

  assign strobe    = wr_en && !gap_q;
  assign t_cs_     = !strobe;
  assign t_as_     = !strobe;
  assign t_rw      = !strobe;
  assign t_addr    = strobe ? {28'd0, wr_addr} : 30'd0;
  assign t_wr_data = strobe ? wr_data : 32'd0;
  assign busy      = (state_q != S_IDLE);
  assign gnt_id    = gnt_q;

  always_comb begin
    done = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      done[i] = (state_q == S_DONE) && (gnt_q == 3'(i));
    end
  end

endmodule

// File: doc/timer_scheduler.md
Name: timer_scheduler

Overview:
- Time-shares the single memory-mapped timer peripheral between CH_NUM requesters. Each requester asks for a one-shot delay in clock cycles.
- The block acts as the timer's only bus master. It arbitrates round-robin, programs the timer, waits for its interrupt, clears it, and signals completion to the granted channel.
- It sits between the per-unit delay requesters and the timer's cs_/as_/rw/addr/wr_data/rdy_/irq port.

Parameters:
- CH_NUM, 4: number of requesting channels (2..8).
- DELAY_W, 32: width of each requested delay; must equal the timer word width of 32.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req  in  CH_NUM  per-channel level request.
- req_delay  in  CH_NUM*DELAY_W  per-channel delay; channel i occupies bits [i*32 +: 32].
- done  out  CH_NUM  one-hot, one-cycle pulse when the granted channel's delay has expired.
- gnt_id  out  3  index of the channel currently being served; valid while busy=1.
- busy  out  1  high from grant until the done pulse, inclusive.
- t_cs_  out  1  timer chip select, active low.
- t_as_  out  1  timer address strobe, active low.
- t_rw  out  1  1 = read, 0 = write; this block only writes.
- t_addr  out  30  timer word address: 0 = CTRL, 1 = INTR, 2 = EXPR, 3 = COUNTER; bits [29:2] always 0.
- t_wr_data  out  32  write data.
- t_rdy_  in  1  timer ready, active low, registered by the timer (arrives one cycle after the strobe).
- t_irq  in  1  timer expiry interrupt, level.

Behaviour:
- Reset values: all outputs idle. t_cs_=1, t_as_=1, t_rw=1, t_addr=0, t_wr_data=0, done=0, busy=0, gnt_id=0. Round-robin pointer=0. FSM goes to IDLE.
- Reset mid-operation: abandon the transaction immediately; no done pulse; no cleanup writes. Timer state is not restored. The next service always starts with a CTRL stop write.
- Timer register encodings:
  - CTRL: bit0 = start, bit1 = mode (0 = one-shot).
  - INTR: bit0 = irq; write 0 to clear.
- Bus write sequencing (one bus cycle):
  - Drive t_cs_=0, t_as_=0, t_rw=0, t_addr and t_wr_data.
  - Hold all of them stable until t_rdy_=0 is sampled.
  - In the next cycle deassert t_cs_/t_as_ for at least one cycle before the next access.
  - Repeated writes during the hold are idempotent by construction.
- FSM states and transitions:
  - IDLE: if any req bit is set, select the first requesting channel at or after the pointer (wrapping). Latch gnt_id and that channel's req_delay. Set busy=1 and go to STOP.
  - STOP: write CTRL=0 -> CLR_CNT.
  - CLR_CNT: write COUNTER=0 -> SET_EXPR.
  - SET_EXPR: write EXPR=latched delay -> CLR_IRQ0.
  - CLR_IRQ0: write INTR=0, to remove any stale irq -> START.
  - START: write CTRL=32'h1 (start, one-shot) -> WAIT_IRQ.
  - WAIT_IRQ: bus idle; on t_irq=1 -> CLR_IRQ.
  - CLR_IRQ: write INTR=0 -> DONE.
  - DONE: pulse done[gnt_id] for exactly one cycle. Set pointer=(gnt_id+1) mod CH_NUM. Set busy=0 in the following cycle and return to IDLE.
- Arbitration:
  - Decided only in IDLE; no preemption.
  - req changes while busy are ignored. The latched delay is used even if req_delay changes.
  - A channel whose req is still high after its done pulse counts as a new request. It is served again only after the other pending channels, because the pointer has moved past it.
- Boundary cases:
  - Delay 0 is legal; the timer fires almost immediately after START.
  - Delay 32'hFFFFFFFF is legal; no internal timeout is applied.
  - All channels requesting: strict round-robin order 0,1,2,3,0,...
  - t_irq high outside WAIT_IRQ is ignored.
- Timer transaction count per service: exactly 6 writes, in the order CTRL, COUNTER, EXPR, INTR, CTRL, INTR.

Test Plan:
- Single channel: req=4'b0001, delay0=10 (bench timer model attached). Required: writes CTRL=0, COUNTER=0, EXPR=10, INTR=0, CTRL=1, then INTR=0 after irq; done=4'b0001 for 1 cycle; busy deasserts; start-write-accepted to done takes 12..16 cycles.
- All four channels requesting from reset with delays 5/6/7/8. Required: done pulses in order ch0, ch1, ch2, ch3, with gnt_id 0,1,2,3.
- Held requester: ch2 holds req through its done while ch0 is also requesting. Required: next grant is ch0 (pointer=3 wraps to 0), then ch2 again.
- Delay 0 on ch1. Required: irq arrives; done[1] pulses; no hang; exactly 6 writes.
- req_delay changed from 20 to 3 after grant. Required: EXPR write carries 20.
- reset asserted during WAIT_IRQ. Required: next cycle t_cs_=t_as_=1, busy=0, no done. A new request after reset starts with a CTRL=0 write.
